// File: rtl/sc_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sc_io_pkg
// Brief    : Register offsets, parameter limits and address decode for sc_io_bus
// Revision : 1.0 - initial release
// ============================================================================
package sc_io_pkg;

    localparam int WIDTH_MIN   = 1;
    localparam int WIDTH_MAX   = 32;
    localparam int NUM_IN_MIN  = 1;
    localparam int NUM_IN_MAX  = 8;
    localparam int NUM_OUT_MIN = 1;
    localparam int NUM_OUT_MAX = 8;

    // Byte offsets inside the 256-byte I/O window
    localparam logic [7:0] OFS_OUT    = 8'h00;
    localparam logic [7:0] OFS_IN     = 8'h20;
    localparam logic [7:0] OFS_STATUS = 8'h40;
    localparam logic [7:0] OFS_MASK   = 8'h44;
    localparam logic [7:0] OFS_CYCLES = 8'h48;
    localparam logic [7:0] OFS_CYCCLR = 8'h4C;

    localparam logic [1:0] ARM_DONE = 2'd3;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_OUT    = 3'd1,
        SEL_IN     = 3'd2,
        SEL_STATUS = 3'd3,
        SEL_MASK   = 3'd4,
        SEL_CYCLES = 3'd5,
        SEL_CYCCLR = 3'd6
    } reg_sel_e;

    // OUT and IN each occupy a 32-byte bank of eight word slots
    function automatic reg_sel_e decode_ofs(input logic [7:0] ofs);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (ofs[7:5] == OFS_OUT[7:5])       sel = SEL_OUT;
        else if (ofs[7:5] == OFS_IN[7:5])   sel = SEL_IN;
        else if (ofs == OFS_STATUS)         sel = SEL_STATUS;
        else if (ofs == OFS_MASK)           sel = SEL_MASK;
        else if (ofs == OFS_CYCLES)         sel = SEL_CYCLES;
        else if (ofs == OFS_CYCCLR)         sel = SEL_CYCCLR;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_io_sync.sv
`default_nettype none
// ============================================================================
// Module   : sc_io_sync
// Brief    : Two-flop input synchronizer with previous-value register and change flag
// Revision : 1.0 - initial release
// ============================================================================
module sc_io_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] sync_out,
    output logic             changed
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign changed  = (sync_q != prev_q);

endmodule
`default_nettype wire

// File: rtl/sc_io_bus.sv
`default_nettype none
// ============================================================================
// Module   : sc_io_bus
// Brief    : Memory-mapped I/O block: output/input ports, change status, IRQ, cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module sc_io_bus
    import sc_io_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter int          NUM_IN  = 2,
    parameter int          NUM_OUT = 3,
    parameter logic [31:0] IO_BASE = 32'h0000_0100
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [31:0]               addr,
    input  logic [31:0]               datain,
    input  logic                      we,
    output logic                      io_sel,
    output logic [31:0]               dataout,
    input  logic [NUM_IN*WIDTH-1:0]   in_ports,
    output logic [NUM_OUT*WIDTH-1:0]  out_ports,
    output logic                      irq
);

    logic [NUM_OUT*WIDTH-1:0] out_q, out_d;
    logic [NUM_IN-1:0]        status_q, status_d;
    logic [NUM_IN-1:0]        mask_q, mask_d;
    logic [31:0]              cycles_q, cycles_d;
    logic [1:0]               arm_q, arm_d;

    logic [NUM_IN*WIDTH-1:0]  in_sync;
    logic [NUM_IN-1:0]        chg;
    logic [7:0]               ofs;
    logic [2:0]               idx;
    reg_sel_e                 sel;
    logic                     wr_en;
    logic [NUM_IN-1:0]        w1c;
    logic [31:0]              rdata;
    logic                     unused_bits;

    assign io_sel      = (addr[31:8] == IO_BASE[31:8]);
    assign ofs         = {addr[7:2], 2'b00};
    assign idx         = addr[4:2];
    assign sel         = decode_ofs(ofs);
    assign wr_en       = we & io_sel;
    assign unused_bits = ^{addr[1:0], datain};

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sync
            sc_io_sync #(
                .WIDTH (WIDTH)
            ) u_sync (
                .clock    (clock),
                .resetn   (resetn),
                .d_in     (in_ports[gi*WIDTH +: WIDTH]),
                .sync_out (in_sync[gi*WIDTH +: WIDTH]),
                .changed  (chg[gi])
            );
        end
    endgenerate

    always_comb begin
        out_d = out_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (wr_en && (sel == SEL_OUT) && (idx == 3'(i)))
                out_d[i*WIDTH +: WIDTH] = datain[WIDTH-1:0];
        end
        w1c      = (wr_en && (sel == SEL_STATUS)) ? datain[NUM_IN-1:0] : '0;
        // A fresh change overrides a coincident clear of the same bit
        status_d = (status_q & ~w1c) | ((arm_q == ARM_DONE) ? chg : '0);
        mask_d   = (wr_en && (sel == SEL_MASK)) ? datain[NUM_IN-1:0] : mask_q;
        cycles_d = (wr_en && (sel == SEL_CYCCLR)) ? 32'd0 : cycles_q + 32'd1;
        arm_d    = (arm_q == ARM_DONE) ? arm_q : arm_q + 2'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_q    <= '0;
            status_q <= '0;
            mask_q   <= '0;
            cycles_q <= '0;
            arm_q    <= '0;
        end else begin
            out_q    <= out_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            cycles_q <= cycles_d;
            arm_q    <= arm_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_OUT: begin
                for (int i = 0; i < NUM_OUT; i++)
                    if (idx == 3'(i)) rdata[WIDTH-1:0] = out_q[i*WIDTH +: WIDTH];
            end
            SEL_IN: begin
                for (int i = 0; i < NUM_IN; i++)
                    if (idx == 3'(i)) rdata[WIDTH-1:0] = in_sync[i*WIDTH +: WIDTH];
            end
            SEL_STATUS: rdata[NUM_IN-1:0] = status_q;
            SEL_MASK:   rdata[NUM_IN-1:0] = mask_q;
            SEL_CYCLES: rdata = cycles_q;
            default:    rdata = '0;
        endcase
    end

    assign dataout   = io_sel ? rdata : 32'd0;
    assign out_ports = out_q;
    assign irq       = |(status_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_sc_io_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_io_bus
// Brief    : Directed self-checking bench for sc_io_bus (WIDTH=8, NUM_IN=2, NUM_OUT=3)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_io_bus;

    localparam int          WIDTH   = 8;
    localparam int          NUM_IN  = 2;
    localparam int          NUM_OUT = 3;
    localparam logic [31:0] IO_BASE = 32'h0000_0100;

    localparam logic [31:0] A_OUT0   = 32'h0000_0100;
    localparam logic [31:0] A_OUT1   = 32'h0000_0104;
    localparam logic [31:0] A_OUT5   = 32'h0000_0114;
    localparam logic [31:0] A_IN0    = 32'h0000_0120;
    localparam logic [31:0] A_IN1    = 32'h0000_0124;
    localparam logic [31:0] A_IN5    = 32'h0000_0134;
    localparam logic [31:0] A_STATUS = 32'h0000_0140;
    localparam logic [31:0] A_MASK   = 32'h0000_0144;
    localparam logic [31:0] A_CYCLES = 32'h0000_0148;
    localparam logic [31:0] A_CYCCLR = 32'h0000_014C;
    localparam logic [31:0] A_HOLE   = 32'h0000_0150;

    logic                      clock  = 1'b0;
    logic                      resetn = 1'b0;
    logic [31:0]               addr   = 32'd0;
    logic [31:0]               datain = 32'd0;
    logic                      we     = 1'b0;
    logic                      io_sel;
    logic [31:0]               dataout;
    logic [NUM_IN*WIDTH-1:0]   in_ports;
    logic [NUM_OUT*WIDTH-1:0]  out_ports;
    logic                      irq;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_data[$];
    string       exp_tag[$];

    sc_io_bus #(
        .WIDTH   (WIDTH),
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT),
        .IO_BASE (IO_BASE)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .addr      (addr),
        .datain    (datain),
        .we        (we),
        .io_sel    (io_sel),
        .dataout   (dataout),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_tag.push_back(tag);
        exp_data.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_assert++;
        if (exp_data.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
        end else begin
            e = exp_data.pop_front();
            t = exp_tag.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] v);
        addr = a;
        we   = 1'b0;
        expect_val(tag, v);
        #1;
        check(dataout);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        datain = d;
        we     = 1'b1;
        @(posedge clock);
        #1;
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        in_ports = 16'h003C;
        #2;
        expect_val("reset_out_ports", 32'd0);
        check({8'd0, out_ports});
        expect_val("reset_irq", 32'd0);
        check({31'd0, irq});

        @(negedge clock);
        resetn = 1'b1;

        // Free-running counter and quiet status after arm
        repeat (10) @(posedge clock);
        #1;
        rd(A_CYCLES, "cycles_after_10", 32'd10);
        rd(A_STATUS, "no_flag_initial_value", 32'd0);
        rd(A_IN0, "in0_initial", 32'h0000_003C);
        tick();
        rd(A_CYCCLR, "cycclr_reads_zero", 32'd0);
        rd(A_IN1, "in1_zero", 32'd0);
        tick();
        wr(A_CYCCLR, 32'h0000_1234);
        rd(A_CYCLES, "cycles_cleared", 32'd0);
        tick();
        rd(A_CYCLES, "cycles_resume", 32'd1);
        tick();
        force dut.cycles_q = 32'hFFFF_FFFF;
        rd(A_CYCLES, "cycles_forced_max", 32'hFFFF_FFFF);
        release dut.cycles_q;
        tick();
        rd(A_CYCLES, "cycles_wrap", 32'd0);

        // Output port write with truncation
        tick();
        wr(A_OUT1, 32'h1234_56A5);
        expect_val("out_ports_after_wr", 32'h0000_A500);
        check({8'd0, out_ports});
        rd(A_OUT1, "out1_readback", 32'h0000_00A5);
        expect_val("io_sel_hit", 32'd1);
        check({31'd0, io_sel});
        rd(A_OUT0, "out0_untouched", 32'd0);

        // Change detection through the synchronizer
        tick();
        in_ports = 16'h003D;
        tick();
        tick();
        rd(A_STATUS, "status_before_3rd_edge", 32'd0);
        rd(A_IN0, "in0_synced", 32'h0000_003D);
        tick();
        rd(A_STATUS, "status_set", 32'd1);
        expect_val("irq_masked_off", 32'd0);
        check({31'd0, irq});

        wr(A_MASK, 32'hFFFF_FFFF);
        expect_val("irq_unmasked", 32'd1);
        check({31'd0, irq});
        rd(A_MASK, "mask_truncated", 32'd3);

        wr(A_STATUS, 32'd1);
        expect_val("irq_after_w1c", 32'd0);
        check({31'd0, irq});
        rd(A_STATUS, "status_cleared", 32'd0);

        // Clear coinciding with a new change: set wins
        tick();
        in_ports = 16'h003E;
        tick();
        tick();
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, "status_set_wins", 32'd1);
        expect_val("irq_set_wins", 32'd1);
        check({31'd0, irq});
        tick();
        rd(A_STATUS, "status_sticky", 32'd1);

        // Unmapped and out-of-range locations
        tick();
        rd(A_HOLE, "hole_reads_zero", 32'd0);
        rd(A_OUT5, "out5_reads_zero", 32'd0);
        rd(A_IN5, "in5_reads_zero", 32'd0);
        tick();
        rd(32'h0000_0200, "unselected_reads_zero", 32'd0);
        expect_val("io_sel_miss", 32'd0);
        check({31'd0, io_sel});
        tick();
        wr(A_HOLE, 32'hFFFF_FFFF);
        wr(A_OUT5, 32'hFFFF_FFFF);
        wr(A_IN5, 32'hFFFF_FFFF);
        wr(32'h0000_0200, 32'hFFFF_FFFF);
        wr(32'h0000_0240, 32'hFFFF_FFFF);
        wr(32'h0000_0244, 32'h0000_0000);
        expect_val("out_ports_unchanged", 32'h0000_A500);
        check({8'd0, out_ports});
        rd(A_MASK, "mask_unchanged", 32'd3);
        rd(A_STATUS, "status_unchanged", 32'd1);

        // Reset in the middle of a write
        tick();
        addr   = A_OUT0;
        datain = 32'h0000_0077;
        we     = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        expect_val("midreset_out_ports", 32'd0);
        check({8'd0, out_ports});
        expect_val("midreset_irq", 32'd0);
        check({31'd0, irq});
        @(posedge clock);
        #1;
        we = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        rd(A_CYCLES, "cycles_after_reset", 32'd0);
        rd(A_OUT0, "out0_write_discarded", 32'd0);
        tick();
        expect_val("out_ports_after_reset", 32'd0);
        check({8'd0, out_ports});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sc_io_bus.md
SC_IO_BUS -- requirements
Module: sc_io_bus

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bits per I/O port (legal 1..32).
REQ-002 SHALL have parameter NUM_IN, default 2, meaning number of input ports (legal 1..8).
REQ-003 SHALL have parameter NUM_OUT, default 3, meaning number of output ports (legal 1..8).
REQ-004 SHALL have parameter IO_BASE, default 32'h0000_0100, meaning 256-byte-aligned base of the I/O region.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port addr  input  32  byte address from CPU ALU result.
REQ-008 SHALL have port datain  input  32  CPU store data.
REQ-009 SHALL have port we  input  1  CPU store strobe.
REQ-010 SHALL have port io_sel  output  1  high when addr[31:8] equals IO_BASE[31:8].
REQ-011 SHALL have port dataout  output  32  read data for the selected I/O register.
REQ-012 SHALL have port in_ports  input  NUM_IN*WIDTH  asynchronous external inputs, port i at [i*WIDTH +: WIDTH].
REQ-013 SHALL have port out_ports  output  NUM_OUT*WIDTH  output port registers, same packing.
REQ-014 SHALL have port irq  output  1  level interrupt request.

Function
REQ-015 Word map SHALL be offset=addr[7:2]: 0x00+4i OUT[i] RW; 0x20+4i IN[i] RO; 0x40 STATUS (bit i sticky change flag, write-1-to-clear); 0x44 MASK RW (NUM_IN bits); 0x48 CYCLES RO; 0x4C CYCCLR (write any value clears CYCLES).
REQ-016 Writes SHALL take effect on the rising clock edge where we=1 and io_sel=1; datain truncated to WIDTH (MASK: NUM_IN bits).
REQ-017 Reads SHALL be combinational from registered state (zero-cycle latency), zero-extended to 32 bits.
REQ-018 Unmapped offsets, OUT[i] with i>=NUM_OUT, and IN[i] with i>=NUM_IN SHALL read 0 and ignore writes.
REQ-019 dataout SHALL be 0 whenever io_sel=0.
REQ-020 Each input port SHALL pass through a 2-flop synchronizer; IN[i] reads the second stage.
REQ-021 A third register per port SHALL hold the previous synchronized value; STATUS[i] sets when stage2 != previous and detection is armed.
REQ-022 Detection SHALL be armed 3 clock cycles after resetn deasserts (2-bit arm counter saturating at 3); no flags set before that.
REQ-023 When a STATUS[i] set and a W1C of bit i coincide, set SHALL win.
REQ-024 CYCLES SHALL increment by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
REQ-025 Write to CYCCLR SHALL load CYCLES with 0 at that edge (clear beats increment); read of CYCCLR returns 0.
REQ-026 irq SHALL equal OR-reduce(STATUS & MASK), derived from registers only (no combinational path from addr/we).
REQ-027 out_ports SHALL be driven directly by OUT registers; an update is visible the cycle after the write edge.

Reset
REQ-028 On resetn=0, asynchronously: OUT, synchronizer stages, previous regs, STATUS, MASK, CYCLES, arm counter SHALL clear to 0; hence out_ports=0, irq=0.
REQ-029 Reset asserted mid-operation SHALL discard any coincident write; no state survives.

Structure
REQ-030 Package sc_io_pkg SHALL hold offset constants (OFS_OUT, OFS_IN, OFS_STATUS, OFS_MASK, OFS_CYCLES, OFS_CYCCLR) and parameter legal limits.
REQ-031 Sub-module sc_io_sync (WIDTH-wide 2-flop synchronizer + previous register + change pulse) SHALL be instantiated NUM_IN times.
REQ-032 Target size 150-300 lines RTL; no memories, no latches.

Verification
REQ-033 Reset then write 32'hA5 to IO_BASE+0x04 (NUM_OUT=3, WIDTH=8) -> out_ports[15:8]=8'hA5 next cycle, other ports 0, read returns 32'h0000_00A5.
REQ-034 in_ports[7:0] held 8'h3C from reset; change 8'h3C->8'h3D after arm -> STATUS=1 on 3rd edge, IN[0] reads 8'h3D; nothing flagged for the initial 8'h3C.
REQ-035 MASK=1, STATUS[0] set -> irq=1; W1C 1 to 0x40 -> irq=0 next cycle; W1C coinciding with new change -> STATUS[0] stays 1.
REQ-036 Let CYCLES run 10 cycles after reset -> read 10; write CYCCLR -> read 0 next cycle, then increments; force wrap from FFFF_FFFF -> 0.
REQ-037 Read 0x50, OUT[5] (NUM_OUT=3), and any address with io_sel=0 -> dataout=0; writes there leave all registers unchanged.
REQ-038 Assert resetn mid-write to OUT[0] -> out_ports=0, irq=0 immediately, CYCLES=0 after release.
